// File: rtl/dmem_pair_arbiter.sv
// rtl/dmem_pair_arbiter.sv - serializes the dual-issue memory-stage pair onto one data-memory port
// Lane 1 is issued first, then lane 2. Both lanes share one timeout counter.
module dmem_pair_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lane1_mem_req,
  input  logic        i_lane1_we,
  input  logic [2:0]  i_lane1_funct3,
  input  logic [31:0] i_lane1_addr,
  input  logic [31:0] i_lane1_wdata,
  input  logic        i_lane2_mem_req,
  input  logic        i_lane2_we,
  input  logic [2:0]  i_lane2_funct3,
  input  logic [31:0] i_lane2_addr,
  input  logic [31:0] i_lane2_wdata,
  input  logic        i_flush_lane2,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [2:0]  o_mem_funct3,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_lane1_rdata,
  output logic [31:0] o_lane2_rdata,
  output logic        o_stall,
  output logic        o_bus_err
);
  typedef enum logic [1:0] {S_IDLE, S_L1, S_L2, S_DONE} state_t;

  localparam logic [7:0] LP_WLAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_pend2;
  logic [7:0]  r_wcnt;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [2:0]  r_mem_funct3;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_lane1_rdata;
  logic [31:0] r_lane2_rdata;
  logic        r_bus_err;

  logic w_lane2_live;
  logic w_timeout;

  assign w_lane2_live = i_lane2_mem_req & ~i_flush_lane2;
  assign w_timeout    = ~i_mem_ready & (r_wcnt == LP_WLAST);

  assign o_stall = ((r_state == S_IDLE) & (i_lane1_mem_req | w_lane2_live))
                 | (r_state == S_L1) | (r_state == S_L2);

  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_funct3  = r_mem_funct3;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_lane1_rdata = r_lane1_rdata;
  assign o_lane2_rdata = r_lane2_rdata;
  assign o_bus_err     = r_bus_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_pend2       <= 1'b0;
      r_wcnt        <= 8'd0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_funct3  <= 3'd0;
      r_mem_addr    <= 32'd0;
      r_mem_wdata   <= 32'd0;
      r_lane1_rdata <= 32'd0;
      r_lane2_rdata <= 32'd0;
      r_bus_err     <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wcnt <= 8'd0;
          if (i_lane1_mem_req) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= i_lane1_we;
            r_mem_funct3 <= i_lane1_funct3;
            r_mem_addr   <= i_lane1_addr;
            r_mem_wdata  <= i_lane1_wdata;
            r_pend2      <= w_lane2_live;
            r_state      <= S_L1;
          end else if (w_lane2_live) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= i_lane2_we;
            r_mem_funct3 <= i_lane2_funct3;
            r_mem_addr   <= i_lane2_addr;
            r_mem_wdata  <= i_lane2_wdata;
            r_pend2      <= 1'b0;
            r_state      <= S_L2;
          end
        end
        S_L1, S_L2: begin
          if (i_mem_ready) begin
            if (!r_mem_we) begin
              if (r_state == S_L1) r_lane1_rdata <= i_mem_rdata;
              else                 r_lane2_rdata <= i_mem_rdata;
            end
            // lane 2 re-sampled here so the second access follows with no gap
            if ((r_state == S_L1) && r_pend2) begin
              r_mem_we     <= i_lane2_we;
              r_mem_funct3 <= i_lane2_funct3;
              r_mem_addr   <= i_lane2_addr;
              r_mem_wdata  <= i_lane2_wdata;
              r_pend2      <= 1'b0;
              r_wcnt       <= 8'd0;
              r_state      <= S_L2;
            end else begin
              r_mem_req <= 1'b0;
              r_state   <= S_DONE;
            end
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_pend2   <= 1'b0;
            r_mem_req <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_pair_arbiter.sv
// tb/tb_dmem_pair_arbiter.sv - scoreboard bench for dmem_pair_arbiter
// Expected accesses are queued at drive time and popped when the memory accepts one.
module tb_dmem_pair_arbiter;
  localparam int TO = 4;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  logic rst;
  logic l1_req, l1_we, l2_req, l2_we, flush;
  logic [2:0] l1_f3, l2_f3;
  logic [31:0] l1_addr, l1_wdata, l2_addr, l2_wdata;
  logic mem_ready;
  logic [31:0] mem_rdata;
  logic o_mem_req, o_mem_we, o_stall, o_bus_err;
  logic [2:0] o_mem_funct3;
  logic [31:0] o_mem_addr, o_mem_wdata, o_lane1_rdata, o_lane2_rdata;

  int n_checks = 0;
  int n_errors = 0;
  acc_t sb[$];
  logic [31:0] exp_rd1, exp_rd2;
  int wait_n = 0;
  logic never_ready = 1'b0;
  int mcnt = 0;
  logic mm_req = 1'b0, mm_ready = 1'b0;
  logic pv_req = 1'b0, pv_ready = 1'b0;
  logic [3:0] pv_ctl;
  logic [31:0] pv_addr, pv_wdata;
  int req_cnt, berr_cnt;

  always #5 clk = ~clk;

  dmem_pair_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_lane1_mem_req(l1_req), .i_lane1_we(l1_we), .i_lane1_funct3(l1_f3),
    .i_lane1_addr(l1_addr), .i_lane1_wdata(l1_wdata),
    .i_lane2_mem_req(l2_req), .i_lane2_we(l2_we), .i_lane2_funct3(l2_f3),
    .i_lane2_addr(l2_addr), .i_lane2_wdata(l2_wdata),
    .i_flush_lane2(flush),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_funct3(o_mem_funct3),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_lane1_rdata(o_lane1_rdata), .o_lane2_rdata(o_lane2_rdata),
    .o_stall(o_stall), .o_bus_err(o_bus_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] img(input logic [31:0] a);
    case (a)
      32'h100: img = 32'hDEADBEEF;
      32'h204: img = 32'h22;
      default: img = a ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic mem_model();
    if (o_mem_req === 1'b1) begin
      if (!mm_req || mm_ready) mcnt = 0;
      else mcnt++;
      mem_ready = !never_ready && (mcnt >= wait_n);
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
    mem_rdata = (mem_ready && o_mem_req === 1'b1) ? img(o_mem_addr) : $urandom;
    mm_req = (o_mem_req === 1'b1);
    mm_ready = mem_ready;
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    mem_model();
  endtask

  task automatic cyc_end();
    acc_t e;
    @(negedge clk);
    if (o_mem_req === 1'b1) req_cnt++;
    if (o_bus_err === 1'b1) berr_cnt++;
    if (o_mem_req === 1'b1 && pv_req && !pv_ready) begin
      chk("hold_addr", o_mem_addr, pv_addr);
      chk("hold_ctl", {o_mem_we, o_mem_funct3}, pv_ctl);
      chk("hold_wdata", o_mem_wdata, pv_wdata);
    end
    if (o_mem_req === 1'b1 && mem_ready) begin
      if (sb.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("acc_addr", o_mem_addr, e.addr);
        chk("acc_ctl", {o_mem_we, o_mem_funct3}, {e.we, e.f3});
        chk("acc_wdata", o_mem_wdata, e.wdata);
      end
    end
    pv_req = (o_mem_req === 1'b1);
    pv_ready = mem_ready;
    pv_addr = o_mem_addr;
    pv_ctl = {o_mem_we, o_mem_funct3};
    pv_wdata = o_mem_wdata;
  endtask

  task automatic clear_inputs();
    l1_req = 0; l1_we = 0; l1_f3 = 0; l1_addr = 0; l1_wdata = 0;
    l2_req = 0; l2_we = 0; l2_f3 = 0; l2_addr = 0; l2_wdata = 0;
    flush = 0;
  endtask

  task automatic do_pair(input logic r1, input logic w1, input logic [2:0] f1,
                         input logic [31:0] a1, input logic [31:0] d1,
                         input logic r2, input logic w2, input logic [2:0] f2,
                         input logic [31:0] a2, input logic [31:0] d2,
                         input logic fl, input int wn, input logic nr);
    int n_acc, exp_req, exp_stall, stall_cnt;
    logic i1, i2;
    i1 = r1;
    i2 = r2 & ~fl;
    n_acc = int'(i1) + int'(i2);
    if (nr) exp_req = (n_acc > 0) ? TO : 0;
    else exp_req = n_acc * (wn + 1);
    exp_stall = (n_acc > 0) ? exp_req + 1 : 0;
    if (!nr) begin
      if (i1) sb.push_back('{w1, f1, a1, d1});
      if (i2) sb.push_back('{w2, f2, a2, d2});
      if (i1 && !w1) exp_rd1 = img(a1);
      if (i2 && !w2) exp_rd2 = img(a2);
    end
    cyc_begin();
    wait_n = wn; never_ready = nr; req_cnt = 0; berr_cnt = 0;
    l1_req = r1; l1_we = w1; l1_f3 = f1; l1_addr = a1; l1_wdata = d1;
    l2_req = r2; l2_we = w2; l2_f3 = f2; l2_addr = a2; l2_wdata = d2;
    flush = fl;
    cyc_end();
    stall_cnt = 0;
    while (o_stall === 1'b1 && stall_cnt < 64) begin
      stall_cnt++;
      cyc_begin();
      cyc_end();
    end
    chk("stall_cycles", stall_cnt, exp_stall);
    chk("req_cycles", req_cnt, exp_req);
    chk("done_req_low", o_mem_req, 0);
    chk("bus_err_done", o_bus_err, (nr && n_acc > 0));
    chk("bus_err_cycles", berr_cnt, (nr && n_acc > 0) ? 1 : 0);
    chk("lane1_rdata", o_lane1_rdata, exp_rd1);
    chk("lane2_rdata", o_lane2_rdata, exp_rd2);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    mem_ready = 0;
    mem_rdata = 0;
    // reset held for two edges while inputs toggle randomly
    for (int i = 0; i < 2; i++) begin
      cyc_begin();
      l1_req = 1'($urandom); l2_req = 1'($urandom); flush = 1'($urandom);
      l1_addr = $urandom; l2_addr = $urandom; l1_we = 1'($urandom);
      cyc_end();
    end
    cyc_begin();
    rst = 0;
    clear_inputs();
    cyc_end();
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_mem_we", o_mem_we, 0);
    chk("rst_funct3", o_mem_funct3, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_rdata1", o_lane1_rdata, 0);
    chk("rst_rdata2", o_lane2_rdata, 0);
    chk("rst_bus_err", o_bus_err, 0);
    chk("rst_stall", o_stall, 0);
    exp_rd1 = 0;
    exp_rd2 = 0;

    do_pair(0, 0, 3'd2, 32'h0, 32'h0, 0, 0, 3'd2, 32'h0, 32'h0, 0, 0, 0);
    do_pair(1, 0, 3'd2, 32'h100, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    do_pair(1, 1, 3'd2, 32'h200, 32'h11, 1, 0, 3'd2, 32'h204, 32'h0, 0, 0, 0);
    do_pair(1, 1, 3'd2, 32'h200, 32'h11, 1, 0, 3'd2, 32'h204, 32'h0, 1, 0, 0);
    do_pair(0, 0, 3'd4, 32'h0, 32'h0, 1, 0, 3'd1, 32'h2F0, 32'h0, 0, 0, 0);
    do_pair(1, 0, 3'd2, 32'h300, 32'h0, 1, 0, 3'd5, 32'h304, 32'h0, 0, 3, 0);
    do_pair(1, 0, 3'd2, 32'h400, 32'h0, 1, 0, 3'd2, 32'h404, 32'h0, 0, 0, 1);
    do_pair(1, 0, 3'd0, 32'h500, 32'h0, 1, 0, 3'd4, 32'h504, 32'h0, 0, 1, 0);

    for (int i = 0; i < 24; i++) begin
      do_pair(1'($urandom), 1'($urandom), 3'($urandom), $urandom & 32'hFFFC, $urandom,
              1'($urandom), 1'($urandom), 3'($urandom), $urandom & 32'hFFFC, $urandom,
              1'($urandom_range(0, 3) == 0), $urandom_range(0, TO - 1), 0);
    end

    // reset while an access is outstanding
    cyc_begin();
    never_ready = 1;
    l1_req = 1; l1_we = 0; l1_addr = 32'h600;
    l2_req = 1; l2_we = 0; l2_addr = 32'h604;
    cyc_end();
    cyc_begin();
    cyc_end();
    chk("mid_req_active", o_mem_req, 1);
    cyc_begin();
    rst = 1;
    cyc_end();
    cyc_begin();
    rst = 0;
    clear_inputs();
    cyc_end();
    chk("mid_rst_req", o_mem_req, 0);
    chk("mid_rst_stall", o_stall, 0);
    exp_rd1 = 0;
    exp_rd2 = 0;
    do_pair(1, 0, 3'd2, 32'h100, 32'h0, 1, 0, 3'd2, 32'h204, 32'h0, 0, 2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
